gpzda_emitter: RTL and testbench

- Serialises one complete NMEA `$GPZDA` sentence as a byte stream with a valid/ready handshake.
- It is the transmit-side counterpart of the GPZDA receive chain: same byte-per-clock `load`/`data` convention that the comparer/parser stage consumes.
- Time, date and zone fields are captured as BCD on `start`.
- The block computes the XOR checksum and appends `*CS\r\n`. Used for loopback testing of the parser and as the UART payload source.

---
 rtl/gpzda_pkg.sv | 56 +++++
 rtl/gpzda_emitter_hex_ascii.sv | 17 +
 rtl/gpzda_emitter.sv | 162 ++++++++++++++++
 tb/tb_gpzda_emitter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpzda_pkg.sv
// Shared types and constants for the $GPZDA sentence emitter.
package gpzda_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned SENTENCE_LEN = 38;
    localparam int unsigned IDX_W        = 6;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(SENTENCE_LEN - 1);

    // Fixed ASCII characters of the sentence frame.
    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_DOT    = 8'h2E;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_Z      = 8'h5A;
    localparam logic [7:0] ASCII_D      = 8'h44;
    localparam logic [7:0] ASCII_A      = 8'h41;

    // First byte index of each numeric field.
    localparam idx_t F_TIME   = 6'd7;
    localparam idx_t F_DAY    = 6'd17;
    localparam idx_t F_MONTH  = 6'd20;
    localparam idx_t F_YEAR   = 6'd23;
    localparam idx_t F_ZONE_H = 6'd28;
    localparam idx_t F_ZONE_M = 6'd31;

    // Checksum window and checksum character positions.
    localparam idx_t CS_FIRST = 6'd1;
    localparam idx_t CS_LAST  = 6'd32;
    localparam idx_t CS_HI    = 6'd34;
    localparam idx_t CS_LO    = 6'd35;

    typedef struct packed {
        logic [31:0] time_bcd;
        logic [7:0]  day;
        logic [7:0]  month;
        logic [15:0] year;
        logic [7:0]  zone_h;
        logic [7:0]  zone_m;
    } fields_t;

    // Digit character is 8'h30 + nibble; non-BCD nibbles follow the same rule.
    function automatic logic [7:0] digit_ascii(input logic [3:0] n);
        return {4'h3, n};
    endfunction

endpackage

// File: rtl/gpzda_emitter_hex_ascii.sv
// Converts a 4-bit nibble into its uppercase hexadecimal ASCII character.
module hex_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // '0'-'9' for 0..9, 'A'-'F' for 10..15.
    always_comb begin
        ascii_o = 8'h00;
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/gpzda_emitter.sv
// Serialises one NMEA $GPZDA sentence, one byte per accepted load/ready beat.
module gpzda_emitter
    import gpzda_pkg::*;
#(
    parameter logic [15:0] TALKER = "GP"
) (
    input  logic        clock,
    input  logic        restart,
    input  logic        start,
    input  logic [31:0] time_bcd,
    input  logic [7:0]  day_bcd,
    input  logic [7:0]  month_bcd,
    input  logic [15:0] year_bcd,
    input  logic [7:0]  zone_h_bcd,
    input  logic [7:0]  zone_m_bcd,
    output logic [7:0]  data,
    output logic        load,
    input  logic        ready,
    output logic        busy,
    output logic        done
);

    state_t  state_q, state_d;
    idx_t    idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    fields_t fields_q, fields_d;

    logic [7:0] byte_sel;
    logic [3:0] hex_nibble;
    logic [7:0] hex_char;

    assign hex_nibble = (idx_q == CS_HI) ? csum_q[7:4] : csum_q[3:0];

    hex_ascii u_hex (
        .nibble_i (hex_nibble),
        .ascii_o  (hex_char)
    );

    // State register; restart has priority over everything, including start.
    always_ff @(posedge clock) begin
        if (restart) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only counts in IDLE, FINISH lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    if (ready && (idx_q == LAST_IDX)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        load = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        data = 8'h00;
        case (state_q)
            SEND: begin
                load = 1'b1;
                busy = 1'b1;
                data = byte_sel;
            end
            FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte at the current index; numeric fields are read from the captured copy.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            6'd0: byte_sel = ASCII_DOLLAR;
            6'd1: byte_sel = TALKER[15:8];
            6'd2: byte_sel = TALKER[7:0];
            6'd3: byte_sel = ASCII_Z;
            6'd4: byte_sel = ASCII_D;
            6'd5: byte_sel = ASCII_A;
            6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd30: byte_sel = ASCII_COMMA;
            6'd13: byte_sel = ASCII_DOT;
            F_TIME:          byte_sel = digit_ascii(fields_q.time_bcd[31:28]);
            F_TIME + 6'd1:   byte_sel = digit_ascii(fields_q.time_bcd[27:24]);
            F_TIME + 6'd2:   byte_sel = digit_ascii(fields_q.time_bcd[23:20]);
            F_TIME + 6'd3:   byte_sel = digit_ascii(fields_q.time_bcd[19:16]);
            F_TIME + 6'd4:   byte_sel = digit_ascii(fields_q.time_bcd[15:12]);
            F_TIME + 6'd5:   byte_sel = digit_ascii(fields_q.time_bcd[11:8]);
            F_TIME + 6'd7:   byte_sel = digit_ascii(fields_q.time_bcd[7:4]);
            F_TIME + 6'd8:   byte_sel = digit_ascii(fields_q.time_bcd[3:0]);
            F_DAY:           byte_sel = digit_ascii(fields_q.day[7:4]);
            F_DAY + 6'd1:    byte_sel = digit_ascii(fields_q.day[3:0]);
            F_MONTH:         byte_sel = digit_ascii(fields_q.month[7:4]);
            F_MONTH + 6'd1:  byte_sel = digit_ascii(fields_q.month[3:0]);
            F_YEAR:          byte_sel = digit_ascii(fields_q.year[15:12]);
            F_YEAR + 6'd1:   byte_sel = digit_ascii(fields_q.year[11:8]);
            F_YEAR + 6'd2:   byte_sel = digit_ascii(fields_q.year[7:4]);
            F_YEAR + 6'd3:   byte_sel = digit_ascii(fields_q.year[3:0]);
            F_ZONE_H:        byte_sel = digit_ascii(fields_q.zone_h[7:4]);
            F_ZONE_H + 6'd1: byte_sel = digit_ascii(fields_q.zone_h[3:0]);
            F_ZONE_M:        byte_sel = digit_ascii(fields_q.zone_m[7:4]);
            F_ZONE_M + 6'd1: byte_sel = digit_ascii(fields_q.zone_m[3:0]);
            6'd33:           byte_sel = ASCII_STAR;
            CS_HI, CS_LO:    byte_sel = hex_char;
            6'd36:           byte_sel = ASCII_CR;
            6'd37:           byte_sel = ASCII_LF;
            default:         byte_sel = 8'h00;
        endcase
    end

    // Datapath next state: capture on start, advance index and fold checksum on each beat.
    always_comb begin
        idx_d    = idx_q;
        csum_d   = csum_q;
        fields_d = fields_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d             = '0;
                    csum_d            = '0;
                    fields_d.time_bcd = time_bcd;
                    fields_d.day      = day_bcd;
                    fields_d.month    = month_bcd;
                    fields_d.year     = year_bcd;
                    fields_d.zone_h   = zone_h_bcd;
                    fields_d.zone_m   = zone_m_bcd;
                end
            end
            SEND: begin
                if (ready) begin
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + idx_t'(1);
                    if ((idx_q >= CS_FIRST) && (idx_q <= CS_LAST)) begin
                        csum_d = csum_q ^ byte_sel;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared by restart.
    always_ff @(posedge clock) begin
        if (restart) begin
            idx_q    <= '0;
            csum_q   <= '0;
            fields_q <= '0;
        end else begin
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            fields_q <= fields_d;
        end
    end

endmodule

// File: tb/tb_gpzda_emitter.sv
// Directed self-checking bench for gpzda_emitter.
module tb_gpzda_emitter;

    logic        clock = 1'b0;
    logic        restart = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] time_bcd = '0;
    logic [7:0]  day_bcd = '0;
    logic [7:0]  month_bcd = '0;
    logic [15:0] year_bcd = '0;
    logic [7:0]  zone_h_bcd = '0;
    logic [7:0]  zone_m_bcd = '0;
    logic [7:0]  data;
    logic        load;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_b [0:37];

    localparam string S_BASIC = "$GPZDA,123456.78,09,10,2021,00,00*67";
    localparam string S_ZERO  = "$GPZDA,000000.00,01,01,2000,00,00*64";
    localparam string S_HEX   = "$GPZDA,000000.00,01,01,2000,00,08*6C";

    gpzda_emitter #(.TALKER(16'h4750)) dut (
        .clock      (clock),
        .restart    (restart),
        .start      (start),
        .time_bcd   (time_bcd),
        .day_bcd    (day_bcd),
        .month_bcd  (month_bcd),
        .year_bcd   (year_bcd),
        .zone_h_bcd (zone_h_bcd),
        .zone_m_bcd (zone_m_bcd),
        .data       (data),
        .load       (load),
        .ready      (ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [31:0] t, input logic [7:0] d, input logic [7:0] m,
                              input logic [15:0] y, input logic [7:0] zh, input logic [7:0] zm);
        time_bcd   = t;
        day_bcd    = d;
        month_bcd  = m;
        year_bcd   = y;
        zone_h_bcd = zh;
        zone_m_bcd = zm;
    endtask

    task automatic set_exp(input string s);
        for (int i = 0; i < 36; i++) exp_b[i] = s[i];
        exp_b[36] = 8'h0D;
        exp_b[37] = 8'h0A;
    endtask

    task automatic kick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("latency_load", {31'd0, load}, 32'd1);
        chk("latency_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic idle_after;
        tick;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_load", {31'd0, load}, 32'd0);
    endtask

    // Receives one sentence starting in SEND; optional backpressure, abort or busy start poke.
    task automatic recv(input bit bp, input int abort_at, input int poke_at, output int span);
        int n;
        int cyc;
        bit ph;
        bit rdy;
        bit poked;
        bit held_v;
        logic [7:0] held;
        n = 0; cyc = 0; ph = 1'b0; poked = 1'b0; held_v = 1'b0; held = 8'h00;
        span = 0;
        while (n < 38 && cyc < 300) begin
            if (abort_at >= 0 && n == abort_at) begin
                restart = 1'b1;
                tick;
                restart = 1'b0;
                chk("abort_load", {31'd0, load}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_data", {24'd0, data}, 32'd0);
                tick;
                chk("abort_nodone", {31'd0, done}, 32'd0);
                chk("abort_idle_load", {31'd0, load}, 32'd0);
                span = cyc;
                ready = 1'b1;
                return;
            end
            if (poke_at >= 0 && n == poke_at && !poked) begin
                start = 1'b1;
                set_fields(32'h99999999, 8'h99, 8'h99, 16'h9999, 8'h99, 8'h99);
                poked = 1'b1;
            end else if (poke_at >= 0) begin
                start = 1'b0;
            end
            rdy = bp ? ph : 1'b1;
            ph = ~ph;
            ready = rdy;
            chk($sformatf("load[%0d]", n), {31'd0, load}, 32'd1);
            chk($sformatf("busy[%0d]", n), {31'd0, busy}, 32'd1);
            chk($sformatf("byte[%0d]", n), {24'd0, data}, {24'd0, exp_b[n]});
            if (held_v) chk($sformatf("hold[%0d]", n), {24'd0, data}, {24'd0, held});
            held_v = !rdy;
            held = data;
            if (rdy) n++;
            tick;
            cyc++;
        end
        if (n < 38) begin
            chk("timeout_bytes", n, 38);
        end else begin
            chk("finish_done", {31'd0, done}, 32'd1);
            chk("finish_load", {31'd0, load}, 32'd0);
            chk("finish_busy", {31'd0, busy}, 32'd1);
        end
        span = cyc;
        ready = 1'b1;
    endtask

    initial begin
        int span;
        int gap;

        // Reset state
        set_fields(32'h12345678, 8'h09, 8'h10, 16'h2021, 8'h00, 8'h00);
        restart = 1'b1;
        tick;
        tick;
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);

        // restart and start together: restart wins
        start = 1'b1;
        tick;
        start = 1'b0;
        restart = 1'b0;
        chk("rst_start_load", {31'd0, load}, 32'd0);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        tick;
        chk("rst_start_idle", {31'd0, load}, 32'd0);

        // 1: basic sentence, full throughput
        set_exp(S_BASIC);
        kick;
        recv(1'b0, -1, -1, span);
        chk("t1_span", span, 38);
        idle_after;

        // 2: alternating backpressure
        kick;
        recv(1'b1, -1, -1, span);
        chk("t2_span", span, 76);
        idle_after;

        // 3: abort after 10 bytes, then a fresh sentence
        kick;
        recv(1'b0, 10, -1, span);
        chk("t3_abort_at", span, 10);
        kick;
        recv(1'b0, -1, -1, span);
        idle_after;

        // 4: start while busy with changed fields
        kick;
        recv(1'b0, -1, 5, span);
        start = 1'b0;
        idle_after;
        tick;
        chk("t4_no_second_a", {31'd0, load}, 32'd0);
        tick;
        chk("t4_no_second_b", {31'd0, load}, 32'd0);

        // 5: checksum values, incl. a hex letter
        set_fields(32'h00000000, 8'h01, 8'h01, 16'h2000, 8'h00, 8'h00);
        set_exp(S_ZERO);
        kick;
        recv(1'b0, -1, -1, span);
        idle_after;
        set_fields(32'h00000000, 8'h01, 8'h01, 16'h2000, 8'h00, 8'h08);
        set_exp(S_HEX);
        kick;
        recv(1'b0, -1, -1, span);
        idle_after;

        // 6: start held high gives back-to-back sentences
        set_fields(32'h12345678, 8'h09, 8'h10, 16'h2021, 8'h00, 8'h00);
        set_exp(S_BASIC);
        start = 1'b1;
        tick;
        chk("t6_first_load", {31'd0, load}, 32'd1);
        recv(1'b0, -1, -1, span);
        gap = 0;
        while (load === 1'b0 && gap < 10) begin
            gap++;
            tick;
        end
        // FINISH cycle plus the IDLE cycle where start is sampled
        chk("t6_gap", gap, 2);
        start = 1'b0;
        recv(1'b0, -1, -1, span);
        idle_after;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
